// File: rtl/pcpi_mul_sweep.sv
// pcpi_mul_sweep: exhaustive operand sweep harness for PCPI multiplier channels.
// Every (a, b) pair of OP_W-bit operands is issued to N_CH channels in
// parallel. Each channel's result is compared against an exact reference
// product, and per-channel error statistics plus sticky timeout flags are
// accumulated. One channel's statistics are shown at a time via stat_sel.
module pcpi_mul_sweep #(
    parameter int OP_W    = 8,
    parameter int N_CH    = 4,
    parameter int ACC_W   = 40,
    parameter int TIMEOUT = 16,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [2:0]          mode,
    output logic                pcpi_valid,
    output logic [N_CH*32-1:0]  pcpi_insn,
    output logic [31:0]         pcpi_rs1,
    output logic [31:0]         pcpi_rs2,
    input  logic [N_CH-1:0]     pcpi_ready,
    input  logic [N_CH-1:0]     pcpi_wr,
    input  logic [N_CH*32-1:0]  pcpi_rd,
    input  logic [SEL_W-1:0]    stat_sel,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W:0]     err_cnt,
    output logic [ACC_W-1:0]    err_sum,
    output logic [31:0]         err_max,
    output logic [N_CH-1:0]     timeout_flag
);

    localparam int CNT_W = 2 * OP_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    localparam int SUM_W = ((ACC_W > 32) ? ACC_W : 32) + 1;

    // The last WAIT cycle is the one in which TIMEOUT cycles have elapsed since ISSUE.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'({ACC_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } sweepState_t;

    sweepState_t        r_state;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic [OP_W-1:0]    r_opA;
    logic [OP_W-1:0]    r_opB;
    logic [2:0]         r_mode;
    logic [TMO_W-1:0]   r_tmoCnt;
    logic [N_CH-1:0]    r_resp;
    logic [N_CH-1:0]    r_tmoFlag;
    logic [31:0]        r_rd     [N_CH];
    logic [CNT_W-1:0]   r_errCnt [N_CH];
    logic [ACC_W-1:0]   r_errSum [N_CH];
    logic [31:0]        r_errMax [N_CH];

    logic               w_signA;
    logic               w_signB;
    logic [31:0]        w_rs1;
    logic [31:0]        w_rs2;
    logic [31:0]        w_ref;
    logic [N_CH-1:0]    w_strobe;
    logic [N_CH-1:0]    w_respNext;
    logic               w_lastPair;
    logic [31:0]        w_absErr  [N_CH];
    logic [ACC_W-1:0]   w_sumNext [N_CH];

    // Operand extension: mode 1 signs both, mode 2 signs only rs1, all other modes are unsigned.
    assign w_signA = (r_mode == 3'd1) || (r_mode == 3'd2);
    assign w_signB = (r_mode == 3'd1);
    assign w_rs1   = {{(32 - OP_W){w_signA & r_opA[OP_W-1]}}, r_opA};
    assign w_rs2   = {{(32 - OP_W){w_signB & r_opB[OP_W-1]}}, r_opB};

    // The low 32 bits of a product do not depend on signedness once operands are extended.
    assign w_ref = w_rs1 * w_rs2;

    // Only a ready that also carries a write-back counts as a response.
    assign w_strobe   = pcpi_ready & pcpi_wr;
    assign w_respNext = r_resp | w_strobe;
    assign w_lastPair = (&r_opA) && (&r_opB);

    assign pcpi_valid   = r_valid;
    assign pcpi_rs1     = w_rs1;
    assign pcpi_rs2     = w_rs2;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_flag = r_tmoFlag;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic signed [32:0] w_diff;
        logic        [32:0] w_mag;
        logic [SUM_W-1:0]   w_sumWide;

        // Channel number sits in funct7 so each channel decodes its own instruction.
        assign pcpi_insn[i*32 +: 32] = {7'(i), 5'b0, 5'b0, r_mode, 5'b0, 7'b0001011};

        // Result and reference are both treated as signed 32-bit values for the difference.
        assign w_diff      = $signed({r_rd[i][31], r_rd[i]}) - $signed({w_ref[31], w_ref});
        assign w_mag       = w_diff[32] ? 33'(-w_diff) : 33'(w_diff);
        assign w_absErr[i] = w_mag[32] ? 32'hFFFF_FFFF : w_mag[31:0];

        // Sum in a wider word so the saturation point can be detected without wrapping.
        assign w_sumWide    = SUM_W'(r_errSum[i]) + SUM_W'(w_absErr[i]);
        assign w_sumNext[i] = (w_sumWide > SUM_MAX) ? {ACC_W{1'b1}} : w_sumWide[ACC_W-1:0];
    end

    // Present the statistics of the channel picked by stat_sel; unmatched selects read as zero.
    always_comb begin
        err_cnt = '0;
        err_sum = '0;
        err_max = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stat_sel == SEL_W'(i)) begin
                err_cnt = r_errCnt[i];
                err_sum = r_errSum[i];
                err_max = r_errMax[i];
            end
        end
    end

    // Sweep sequencer: issue a pair, collect responses or time out, accumulate, then advance.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_mode    <= 3'd0;
            r_tmoCnt  <= '0;
            r_resp    <= '0;
            r_tmoFlag <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_rd[i]     <= '0;
                r_errCnt[i] <= '0;
                r_errSum[i] <= '0;
                r_errMax[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_opA     <= '0;
                        r_opB     <= '0;
                        r_mode    <= mode;
                        r_resp    <= '0;
                        r_tmoFlag <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            r_errCnt[i] <= '0;
                            r_errSum[i] <= '0;
                            r_errMax[i] <= '0;
                        end
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_resp   <= '0;
                    r_tmoCnt <= TMO_W'(1);
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    r_resp <= w_respNext;
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_strobe[i] && !r_resp[i]) begin
                            r_rd[i] <= pcpi_rd[i*32 +: 32];
                        end
                    end
                    if ((&w_respNext) || (r_tmoCnt >= TMO_LAST)) begin
                        r_tmoFlag <= r_tmoFlag | ~w_respNext;
                        r_valid   <= 1'b0;
                        r_state   <= S_ACCUM;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + TMO_W'(1);
                    end
                end

                S_ACCUM: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (r_resp[i]) begin
                            r_errCnt[i] <= r_errCnt[i] + CNT_W'(w_absErr[i] != 32'd0);
                            r_errSum[i] <= w_sumNext[i];
                            if (w_absErr[i] > r_errMax[i]) begin
                                r_errMax[i] <= w_absErr[i];
                            end
                        end
                    end
                    if (w_lastPair) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_opB <= r_opB + OP_W'(1);
                        if (&r_opB) begin
                            r_opA <= r_opA + OP_W'(1);
                        end
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_mul_sweep.sv
// tb_pcpi_mul_sweep: drives pcpi_mul_sweep with behavioural multiplier
// responders and compares the reported statistics against a pair-by-pair
// arithmetic reference model.
module tb_pcpi_mul_sweep;

    localparam int OP_W        = 4;
    localparam int N_CH        = 4;
    localparam int ACC_W       = 36;
    localparam int TIMEOUT     = 16;
    localparam int SEL_W       = 2;
    localparam int NPAIR       = 1 << (2 * OP_W);
    localparam int SWEEP_LIMIT = 20000;
    localparam int BH_EXACT    = 0;
    localparam int BH_PLUS1    = 1;
    localparam int BH_SILENT   = 2;
    localparam int BH_RANDOM   = 3;
    localparam longint SUM_CAP = (longint'(1) << ACC_W) - 1;

    logic                clk = 1'b0;
    logic                aresetn;
    logic                start;
    logic [2:0]          mode;
    logic                pcpi_valid;
    logic [N_CH*32-1:0]  pcpi_insn;
    logic [31:0]         pcpi_rs1;
    logic [31:0]         pcpi_rs2;
    logic [N_CH-1:0]     pcpi_ready;
    logic [N_CH-1:0]     pcpi_wr;
    logic [N_CH*32-1:0]  pcpi_rd;
    logic [SEL_W-1:0]    stat_sel;
    logic                busy;
    logic                done;
    logic [2*OP_W:0]     err_cnt;
    logic [ACC_W-1:0]    err_sum;
    logic [31:0]         err_max;
    logic [N_CH-1:0]     timeout_flag;

    pcpi_mul_sweep #(
        .OP_W    (OP_W),
        .N_CH    (N_CH),
        .ACC_W   (ACC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .start        (start),
        .mode         (mode),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .pcpi_ready   (pcpi_ready),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .stat_sel     (stat_sel),
        .busy         (busy),
        .done         (done),
        .err_cnt      (err_cnt),
        .err_sum      (err_sum),
        .err_max      (err_max),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state for the sweep in flight.
    int              behav [N_CH];
    int              tbMode;
    int              pairIdx;
    int              rsBad;
    int              insnBad;
    logic [31:0]     rs1At136;
    logic [31:0]     rs2At136;
    longint          expCnt [N_CH];
    longint          expSum [N_CH];
    longint          expMax [N_CH];
    logic [N_CH-1:0] expTmo;
    longint          expCycles;

    // Responder plan for the pair in flight.
    int              planLat   [N_CH];
    logic [31:0]     planVal   [N_CH];
    bit              planResp  [N_CH];
    bit              planDup   [N_CH];
    bit              planNoise [N_CH];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint extendOp(input int v, input bit sgn);
        if (sgn && v >= (1 << (OP_W - 1))) return longint'(v) - (longint'(1) << OP_W);
        return longint'(v);
    endfunction

    function automatic longint absErr(input logic [31:0] got, input logic [31:0] want);
        longint d;
        d = longint'($signed(got)) - longint'($signed(want));
        if (d < 0) d = -d;
        if (d > 64'hFFFF_FFFF) d = 64'hFFFF_FFFF;
        return d;
    endfunction

    task automatic resetModel(input int m);
        tbMode    = m;
        pairIdx   = 0;
        rsBad     = 0;
        insnBad   = 0;
        expCycles = 0;
        expTmo    = '0;
        for (int c = 0; c < N_CH; c++) begin
            expCnt[c] = 0;
            expSum[c] = 0;
            expMax[c] = 0;
        end
    endtask

    // Decide every channel's answer for the next pair and fold it into the expected statistics.
    task automatic planPair();
        int          a;
        int          b;
        int          sel;
        int          maxLat;
        bit          allIn;
        longint      av;
        longint      bv;
        longint      e;
        logic [31:0] ref32;
        logic [31:0] expInsn;
        a  = pairIdx >> OP_W;
        b  = pairIdx & ((1 << OP_W) - 1);
        av = extendOp(a, (tbMode == 1) || (tbMode == 2));
        bv = extendOp(b, tbMode == 1);
        if (pcpi_rs1 !== 32'(av) || pcpi_rs2 !== 32'(bv)) rsBad++;
        for (int c = 0; c < N_CH; c++) begin
            expInsn = (32'(c) << 25) | (32'(tbMode) << 12) | 32'h0000_000B;
            if (pcpi_insn[c*32 +: 32] !== expInsn) insnBad++;
        end
        if (pairIdx == 136) begin
            rs1At136 = pcpi_rs1;
            rs2At136 = pcpi_rs2;
        end
        ref32  = 32'(av * bv);
        maxLat = 0;
        allIn  = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            planDup[c]   = 1'b0;
            planNoise[c] = 1'b0;
            planResp[c]  = 1'b1;
            planLat[c]   = 1;
            planVal[c]   = ref32;
            case (behav[c])
                BH_PLUS1:  planVal[c] = ref32 + 32'd1;
                BH_SILENT: planResp[c] = 1'b0;
                BH_RANDOM: begin
                    planLat[c]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 20)) : int'($urandom_range(1, 6));
                    planResp[c] = ($urandom_range(0, 9) != 0);
                    sel = $urandom_range(0, 9);
                    if (sel >= 5 && sel < 8) begin
                        if ($urandom_range(0, 1) == 0) planVal[c] = ref32 + 32'($urandom_range(1, 500));
                        else                           planVal[c] = ref32 - 32'($urandom_range(1, 500));
                    end else if (sel >= 8) begin
                        planVal[c] = $urandom();
                    end
                    planDup[c]   = ($urandom_range(0, 3) == 0);
                    planNoise[c] = ($urandom_range(0, 3) == 0);
                end
                default: ;
            endcase
            if (planResp[c] && planLat[c] <= TIMEOUT - 1) begin
                e = absErr(planVal[c], ref32);
                if (e != 0) expCnt[c]++;
                expSum[c] = (expSum[c] + e > SUM_CAP) ? SUM_CAP : expSum[c] + e;
                if (e > expMax[c]) expMax[c] = e;
                if (planLat[c] > maxLat) maxLat = planLat[c];
            end else begin
                expTmo[c] = 1'b1;
                allIn     = 1'b0;
            end
        end
        expCycles += longint'((allIn ? maxLat : TIMEOUT - 1) + 2);
        pairIdx++;
    endtask

    // Multiplier channels: answer a request 'latency' cycles after it is first seen.
    initial begin : responder
        int k;
        k          = 0;
        pcpi_ready = '0;
        pcpi_wr    = '0;
        pcpi_rd    = '0;
        forever begin
            @(negedge clk);
            pcpi_ready = '0;
            pcpi_wr    = '0;
            pcpi_rd    = '0;
            if (pcpi_valid !== 1'b1) begin
                k = 0;
            end else begin
                k++;
                if (k == 1) planPair();
                for (int c = 0; c < N_CH; c++) begin
                    if (planResp[c] && k == planLat[c] + 1) begin
                        pcpi_ready[c]        = 1'b1;
                        pcpi_wr[c]           = 1'b1;
                        pcpi_rd[c*32 +: 32]  = planVal[c];
                    end else if (planResp[c] && planDup[c] && k == planLat[c] + 2) begin
                        pcpi_ready[c]        = 1'b1;
                        pcpi_wr[c]           = 1'b1;
                        pcpi_rd[c*32 +: 32]  = ~planVal[c];
                    end else if (planNoise[c] && k >= 2 && (!planResp[c] || k <= planLat[c])) begin
                        pcpi_ready[c]        = 1'b1;
                        pcpi_wr[c]           = 1'b0;
                        pcpi_rd[c*32 +: 32]  = $urandom();
                    end
                end
            end
        end
    end

    task automatic setBehaviour(input int b0, input int b1, input int b2, input int b3);
        behav[0] = b0;
        behav[1] = b1;
        behav[2] = b2;
        behav[3] = b3;
    endtask

    // Pulse start with the given mode, scramble mode mid-sweep, and count cycles until done.
    task automatic applyStimulus(input int m, output int cycles);
        resetModel(m);
        @(negedge clk);
        mode  = 3'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        mode   = 3'($urandom_range(0, 7));
        cycles = 0;
        while (done !== 1'b1 && cycles < SWEEP_LIMIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic readStats(input int c, output logic [63:0] cnt, output logic [63:0] sum, output logic [63:0] mx);
        stat_sel = SEL_W'(c);
        #1;
        cnt = 64'(err_cnt);
        sum = 64'(err_sum);
        mx  = 64'(err_max);
    endtask

    task automatic checkSweep(input string name, input int cycles);
        logic [63:0] cnt;
        logic [63:0] sum;
        logic [63:0] mx;
        checkOutput($sformatf("%s done", name), 64'(done), 64'd1);
        checkOutput($sformatf("%s busy", name), 64'(busy), 64'd0);
        checkOutput($sformatf("%s valid", name), 64'(pcpi_valid), 64'd0);
        checkOutput($sformatf("%s cycles", name), 64'(cycles), 64'(expCycles));
        checkOutput($sformatf("%s rsBad", name), 64'(rsBad), 64'd0);
        checkOutput($sformatf("%s insnBad", name), 64'(insnBad), 64'd0);
        checkOutput($sformatf("%s timeoutFlag", name), 64'(timeout_flag), 64'(expTmo));
        for (int c = 0; c < N_CH; c++) begin
            readStats(c, cnt, sum, mx);
            checkOutput($sformatf("%s ch%0d errCnt", name, c), cnt, 64'(expCnt[c]));
            checkOutput($sformatf("%s ch%0d errSum", name, c), sum, 64'(expSum[c]));
            checkOutput($sformatf("%s ch%0d errMax", name, c), mx, 64'(expMax[c]));
        end
    endtask

    task automatic checkAllZero(input string name);
        logic [63:0] cnt;
        logic [63:0] sum;
        logic [63:0] mx;
        checkOutput($sformatf("%s busy", name), 64'(busy), 64'd0);
        checkOutput($sformatf("%s done", name), 64'(done), 64'd0);
        checkOutput($sformatf("%s valid", name), 64'(pcpi_valid), 64'd0);
        checkOutput($sformatf("%s timeoutFlag", name), 64'(timeout_flag), 64'd0);
        for (int c = 0; c < N_CH; c++) begin
            readStats(c, cnt, sum, mx);
            checkOutput($sformatf("%s ch%0d stats", name, c), cnt | sum | mx, 64'd0);
        end
    endtask

    // Backstop in case the design never reaches the states the bench waits for.
    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int          cycles;
        int          waitCnt;
        logic [63:0] cnt;
        logic [63:0] sum;
        logic [63:0] mx;

        aresetn  = 1'b0;
        start    = 1'b0;
        mode     = 3'd0;
        stat_sel = '0;
        setBehaviour(BH_EXACT, BH_EXACT, BH_EXACT, BH_EXACT);
        resetModel(0);
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("idleAfterReset");

        $display("[TB] exact responders, mode 0");
        applyStimulus(0, cycles);
        checkSweep("exact", cycles);
        checkOutput("exact cycles768", 64'(cycles), 64'd768);

        $display("[TB] channel 2 returns ref+1");
        setBehaviour(BH_EXACT, BH_EXACT, BH_PLUS1, BH_EXACT);
        applyStimulus(0, cycles);
        checkSweep("plus1", cycles);
        readStats(2, cnt, sum, mx);
        checkOutput("plus1 ch2 cnt256", cnt, 64'd256);
        checkOutput("plus1 ch2 sum256", sum, 64'd256);
        checkOutput("plus1 ch2 max1", mx, 64'd1);

        $display("[TB] channel 3 silent");
        setBehaviour(BH_EXACT, BH_EXACT, BH_EXACT, BH_SILENT);
        applyStimulus(0, cycles);
        checkSweep("silent", cycles);
        checkOutput("silent flags", 64'(timeout_flag), 64'b1000);
        checkOutput("silent cycles", 64'(cycles), 64'(NPAIR * 17));
        readStats(2, cnt, sum, mx);
        checkOutput("silent ch2 cleared", cnt | sum | mx, 64'd0);

        $display("[TB] signed mode 1");
        setBehaviour(BH_EXACT, BH_EXACT, BH_EXACT, BH_EXACT);
        applyStimulus(1, cycles);
        checkSweep("signed", cycles);
        checkOutput("signed rs1 a=-8", 64'(rs1At136), 64'hFFFF_FFF8);
        checkOutput("signed rs2 b=-8", 64'(rs2At136), 64'hFFFF_FFF8);

        for (int t = 0; t < 4; t++) begin
            int m;
            m = (t == 0) ? 2 : (t == 1) ? 1 : int'($urandom_range(0, 7));
            $display("[TB] random responders, mode %0d", m);
            setBehaviour(BH_RANDOM, BH_RANDOM, BH_RANDOM, BH_RANDOM);
            applyStimulus(m, cycles);
            checkSweep($sformatf("random%0d", t), cycles);
        end

        $display("[TB] restart while busy, then reset mid-sweep");
        setBehaviour(BH_EXACT, BH_EXACT, BH_EXACT, BH_EXACT);
        resetModel(0);
        @(negedge clk);
        mode  = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        mode  = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCnt = 0;
        while (pairIdx <= 100 && waitCnt < SWEEP_LIMIT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("abort reachedPair100", 64'(pairIdx > 100), 64'd1);
        checkOutput("abort busyBefore", 64'(busy), 64'd1);
        checkOutput("abort secondStartIgnored", 64'(insnBad), 64'd0);
        aresetn = 1'b0;
        #1;
        checkAllZero("abortInReset");
        @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        checkAllZero("abortIdle");
        applyStimulus(0, cycles);
        checkSweep("afterAbort", cycles);
        checkOutput("afterAbort cycles768", 64'(cycles), 64'd768);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pcpi_mul_sweep.md
PCPI_MUL_SWEEP -- requirements
Module: pcpi_mul_sweep

Interface
REQ-001 SHALL have parameter OP_W, default 8, operand width swept exhaustively (legal 2..16).
REQ-002 SHALL have parameter N_CH, default 4, number of PCPI multiplier channels driven in parallel.
REQ-003 SHALL have parameter ACC_W, default 40, width of each error-sum accumulator.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for a channel response.
REQ-005 SHALL have ports:
- clk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep.
- mode  in  3  func3 of issued instructions: 0 unsigned x unsigned, 1 signed x signed, 2 signed(rs1) x unsigned(rs2).
- pcpi_valid  out  1  PCPI request valid, shared by all channels.
- pcpi_insn  out  N_CH*32  per-channel instruction; channel i = {7'(i), 5'b0, 5'b0, mode, 5'b0, 7'b0001011}.
- pcpi_rs1, pcpi_rs2  out  32 each  operands a, b, extended to 32 bits per mode.
- pcpi_ready  in  N_CH  per-channel response strobe.
- pcpi_wr  in  N_CH  per-channel write-back flag.
- pcpi_rd  in  N_CH*32  per-channel result.
- stat_sel  in  ceil(log2 N_CH)  channel whose statistics are shown.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete.
- err_cnt  out  2*OP_W+1  mismatching pairs, selected channel.
- err_sum  out  ACC_W  sum of absolute errors, selected channel.
- err_max  out  32  largest absolute error, selected channel.
- timeout_flag  out  N_CH  sticky per-channel timeout.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, ACCUM, DONE.
REQ-007 IDLE/DONE: start=1 SHALL clear all statistics and timeout flags, set a=b=0, latch mode, go to ISSUE; busy=1 from the next cycle.
REQ-008 start and mode SHALL be ignored while busy=1; changes to mode mid-sweep SHALL have no effect.
REQ-009 ISSUE: pcpi_valid SHALL assert with current operands and the transition SHALL be to WAIT.
REQ-010 WAIT: per channel, the first cycle with pcpi_ready&pcpi_wr SHALL capture pcpi_rd and mark the channel responded; later strobes in the same pair SHALL be ignored.
REQ-011 pcpi_ready without pcpi_wr SHALL count as no response.
REQ-012 WAIT SHALL exit to ACCUM when all channels have responded, or when TIMEOUT cycles have elapsed since ISSUE; non-responding channels SHALL set their timeout_flag bit.
REQ-013 pcpi_valid SHALL deassert in the ACCUM cycle, giving at least one idle cycle between requests.
REQ-014 Operand extension SHALL be as follows:
- mode 0: rs1 and rs2 zero-extended.
- mode 1: rs1 and rs2 sign-extended from OP_W.
- mode 2: rs1 sign-extended, rs2 zero-extended.
- Any other mode: treated as mode 0 for extension and reference.
REQ-015 ACCUM reference SHALL be the exact 32-bit product of the extended operands (low 32 bits).
REQ-016 ACCUM, per responded channel:
- abs_err = |pcpi_rd - ref|, computed as a 33-bit signed difference and then magnitude, saturated to 32 bits.
- abs_err != 0: err_cnt increments.
- err_sum += abs_err.
- err_max = max(err_max, abs_err).
REQ-017 Timed-out channels SHALL not update err_cnt, err_sum or err_max for that pair.
REQ-018 err_sum SHALL saturate at all-ones and not wrap.
REQ-019 After ACCUM, operands SHALL advance with b as the inner counter (b wraps to 0 and a increments); after the pair a=b=2^OP_W-1, the FSM SHALL go to DONE, otherwise to ISSUE.
REQ-020 Per-pair cost SHALL be (response latency + 2) cycles; a sweep with 1-cycle responders SHALL take 3*2^(2*OP_W) cycles from ISSUE entry to DONE.
REQ-021 DONE: busy=0, done=1, statistics held until the next start.
REQ-022 Stat outputs SHALL be combinational muxes of registered per-channel values indexed by stat_sel; stat_sel >= N_CH SHALL output zeros.
REQ-023 pcpi_insn SHALL be constant during a sweep and reflect latched mode.

Reset
REQ-024 aresetn=0 SHALL asynchronously force:
- FSM to IDLE.
- pcpi_valid=0, busy=0, done=0.
- a=b=0, latched mode=0.
- All err_cnt, err_sum, err_max, timeout_flag values to 0.
REQ-025 Reset asserted mid-sweep SHALL abort it; captured results SHALL be discarded, and after release the block SHALL remain in IDLE until start.

Verification
REQ-026 OP_W=4, N_CH=4, exact 1-cycle responders, mode 0, start -> done after 768 cycles, all channels err_cnt=0, err_sum=0, err_max=0, timeout_flag=0.
REQ-027 Channel 2 returns ref+1, others exact, mode 0 -> channel 2: err_cnt=256, err_sum=256, err_max=1; other channels zero.
REQ-028 Channel 3 never asserts ready, TIMEOUT=16 -> timeout_flag=4'b1000, sweep completes, channel 3 statistics zero, each pair lasting 17 cycles.
REQ-029 Mode 1, OP_W=4, exact signed responders; check a=-8, b=-8 issues rs1=rs2=32'hFFFFFFF8 and ref=64 -> all err_cnt=0.
REQ-030 start pulsed while busy, then aresetn pulsed at pair 100 -> the second start is ignored; after reset busy=0, done=0, stats=0, pcpi_valid=0, and a new start gives a full clean sweep.
